// File: rtl/stream_gen.sv
// stream_gen: command-driven valid/ready stream source.
// Accepts a burst command (base, step, length) and emits `length` words
// base, base+step, base+2*step, ... (mod 2^WIDTH) on a valid/ready port.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_ni         synchronous active-low reset
//   cmd_valid_i    command offered
//   cmd_ready_o    command accepted when high with cmd_valid_i (state decode)
//   cmd_base_i     first data word of burst
//   cmd_step_i     increment between words
//   cmd_len_i      beat count, 0 = no beats
//   valid_out_o    output beat valid
//   data_out_o     output beat data
//   last_out_o     final beat marker, qualified by valid_out_o
//   ready_out_i    downstream ready
//   busy_o         burst in progress
//   done_o         one-cycle pulse on burst completion
//   beats_sent_o   handshaked beats in current/last burst
module stream_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [WIDTH-1:0] cmd_base_i,
  input  logic [WIDTH-1:0] cmd_step_i,
  input  logic [CNT_W-1:0] cmd_len_i,
  output logic             valid_out_o,
  output logic [WIDTH-1:0] data_out_o,
  output logic             last_out_o,
  input  logic             ready_out_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] beats_sent_o
);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] step_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] beats_q;
  logic             last_q;
  logic             done_q;

  logic accept;
  logic handshake;

  assign accept    = (state_q == IDLE) && cmd_valid_i;
  assign handshake = (state_q == SEND) && ready_out_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && (cmd_len_i != '0)) begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_out_i && (rem_q == CNT_W'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: pure state decode, no input-to-output path
  always_comb begin
    cmd_ready_o = (state_q == IDLE);
    valid_out_o = (state_q == SEND);
    busy_o      = (state_q == SEND);
  end

  // Datapath. last/done are computed one beat ahead so they come straight
  // from flops: last rises when the beat about to be shown is remaining==1,
  // done pulses after the handshake that consumes remaining==1.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        data_q  <= cmd_base_i;
        step_q  <= cmd_step_i;
        rem_q   <= cmd_len_i;
        beats_q <= '0;
        last_q  <= (cmd_len_i == CNT_W'(1));
        done_q  <= (cmd_len_i == '0);
      end else if (handshake) begin
        data_q  <= data_q + step_q;
        rem_q   <= rem_q - CNT_W'(1);
        beats_q <= beats_q + CNT_W'(1);
        last_q  <= (rem_q == CNT_W'(2));
        done_q  <= (rem_q == CNT_W'(1));
      end
    end
  end

  assign data_out_o   = data_q;
  assign last_out_o   = last_q;
  assign done_o       = done_q;
  assign beats_sent_o = beats_q;

endmodule

// File: tb/tb_stream_gen.sv
// Self-checking bench for stream_gen: directed scenarios plus randomized
// bursts, each beat checked against base + k*step computed in the bench.
module tb_stream_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_base_i;
  logic [31:0] cmd_step_i;
  logic [15:0] cmd_len_i;
  logic        valid_out_o;
  logic [31:0] data_out_o;
  logic        last_out_o;
  logic        ready_out_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] beats_sent_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  stream_gen #(.WIDTH(32), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_base_i   (cmd_base_i),
    .cmd_step_i   (cmd_step_i),
    .cmd_len_i    (cmd_len_i),
    .valid_out_o  (valid_out_o),
    .data_out_o   (data_out_o),
    .last_out_o   (last_out_o),
    .ready_out_i  (ready_out_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .beats_sent_o (beats_sent_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, obs, exp, $time);
    end
  endtask

  // mode 0: ready always high; 1: fixed 1,0,0,1,0,1,1 pattern; 2: random
  function automatic logic pick_ready(input int unsigned mode, input int unsigned idx);
    logic [6:0] pat;
    pat = 7'b1101001; // bit i = pattern element i
    case (mode)
      0:       return 1'b1;
      1:       return pat[idx % 7];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one burst from an idle DUT; starts and ends at a negedge.
  task automatic run_burst(input logic [31:0] base, input logic [31:0] step,
                           input logic [15:0] len, input int unsigned mode);
    int unsigned k, cyc, idx;
    logic [31:0] exp;
    logic        rdy;
    check("pre_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_base_i  = base;
    cmd_step_i  = step;
    cmd_len_i   = len;
    @(negedge clk_i);
    // fields must have been captured at acceptance only
    cmd_valid_i = 1'b0;
    cmd_base_i  = $urandom;
    cmd_step_i  = $urandom;
    cmd_len_i   = 16'($urandom);
    k = 0; cyc = 0; idx = 0;
    while (k < 32'(len) && cyc < 20 * 32'(len) + 50) begin
      exp = base + step * k;
      check("valid", valid_out_o, 1);
      check("busy", busy_o, 1);
      check("cmd_ready_busy", cmd_ready_o, 0);
      check("data", data_out_o, exp);
      check("last", last_out_o, (k == 32'(len) - 1) ? 1 : 0);
      check("done_mid", done_o, 0);
      rdy = pick_ready(mode, idx);
      idx++;
      ready_out_i = rdy;
      @(negedge clk_i);
      if (rdy) k++;
      cyc++;
    end
    if (k != 32'(len)) begin
      check("burst_timeout", k, 32'(len));
    end
    ready_out_i = 1'($urandom_range(0, 1));
    check("end_valid", valid_out_o, 0);
    check("end_busy", busy_o, 0);
    check("end_done", done_o, 1);
    check("end_beats", beats_sent_o, 32'(len));
    check("end_cmd_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    check("done_pulse_once", done_o, 0);
    check("beats_hold", beats_sent_o, 32'(len));
    check("idle_valid", valid_out_o, 0);
  endtask

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_base_i  = '0;
    cmd_step_i  = '0;
    cmd_len_i   = '0;
    ready_out_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_valid", valid_out_o, 0);
    check("rst_data", data_out_o, 0);
    check("rst_last", last_out_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_beats", beats_sent_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Basic burst, stalled burst, wrap, zero length
    run_burst(32'h10, 32'h4, 16'd4, 0);
    run_burst(32'h10, 32'h4, 16'd4, 1);
    run_burst(32'hFFFF_FFFE, 32'h1, 16'd3, 0);
    run_burst(32'h1234, 32'h1, 16'd0, 0);
    check("len0_valid", valid_out_o, 0);
    run_burst(32'hA5, 32'h3, 16'd1, 2);

    // Back-to-back: second command held during burst 1
    cmd_valid_i = 1'b1; cmd_base_i = 32'h100; cmd_step_i = 32'h1; cmd_len_i = 16'd2;
    ready_out_i = 1'b1;
    @(negedge clk_i);
    cmd_base_i = 32'h200; cmd_step_i = 32'h10; cmd_len_i = 16'd2;
    check("b2b_d0", data_out_o, 32'h100);
    check("b2b_l0", last_out_o, 0);
    @(negedge clk_i);
    check("b2b_d1", data_out_o, 32'h101);
    check("b2b_l1", last_out_o, 1);
    check("b2b_not_accepted", cmd_ready_o, 0);
    @(negedge clk_i);
    check("b2b_gap_valid", valid_out_o, 0);
    check("b2b_gap_done", done_o, 1);
    check("b2b_gap_beats", beats_sent_o, 2);
    check("b2b_gap_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0; cmd_base_i = $urandom; cmd_step_i = $urandom;
    check("b2b2_valid", valid_out_o, 1);
    check("b2b2_d0", data_out_o, 32'h200);
    check("b2b2_beats_clr", beats_sent_o, 0);
    check("b2b2_done", done_o, 0);
    @(negedge clk_i);
    check("b2b2_d1", data_out_o, 32'h210);
    check("b2b2_l1", last_out_o, 1);
    @(negedge clk_i);
    check("b2b2_end_done", done_o, 1);
    check("b2b2_end_beats", beats_sent_o, 2);
    @(negedge clk_i);

    // Reset after 2 of 5 beats
    cmd_valid_i = 1'b1; cmd_base_i = 32'h50; cmd_step_i = 32'h2; cmd_len_i = 16'd5;
    ready_out_i = 1'b1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("mid_beats", beats_sent_o, 2);
    check("mid_data", data_out_o, 32'h54);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check("abort_valid", valid_out_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_beats", beats_sent_o, 0);
    check("abort_done", done_o, 0);
    check("abort_data", data_out_o, 0);
    check("abort_ready", cmd_ready_o, 1);
    @(negedge clk_i);
    check("abort_no_done", done_o, 0);
    run_burst(32'h7, 32'h5, 16'd3, 1);

    // Randomized bursts
    for (int i = 0; i < 40; i++) begin
      run_burst($urandom, $urandom, 16'($urandom_range(0, 12)), 32'($urandom_range(0, 2)));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_gen.md
# stream_gen

Command-driven valid/ready stream source. It accepts a burst command (base, step, length) and emits `length` data words on a valid/ready output port, with backpressure and a last-beat marker. It is the transmitting end for the team's valid/ready pipeline stages, used as a traffic source in datapath bring-up and as a programmable pattern generator.

## Interface
- `WIDTH`, 32, data word width
- `CNT_W`, 16, burst length / beat counter width

Ports:
- `clk_i`  in  1  clock; all logic on rising edge
- `rst_ni`  in  1  reset, synchronous, active-low
- `cmd_valid_i`  in  1  command offered
- `cmd_ready_o`  out  1  command accepted when high with `cmd_valid_i`
- `cmd_base_i`  in  WIDTH  first data word of burst
- `cmd_step_i`  in  WIDTH  increment between consecutive words
- `cmd_len_i`  in  CNT_W  number of beats; 0 is legal and means no beats
- `valid_out_o`  out  1  output beat valid
- `data_out_o`  out  WIDTH  output beat data
- `last_out_o`  out  1  high on the final beat of a burst, qualified by `valid_out_o`
- `ready_out_i`  in  1  downstream ready
- `busy_o`  out  1  burst in progress (state SEND)
- `done_o`  out  1  one-cycle pulse on burst completion
- `beats_sent_o`  out  CNT_W  handshaked beats in current/last burst

## Operation
- States: IDLE, SEND.
- IDLE: `cmd_ready_o`=1, `valid_out_o`=0. On `cmd_valid_i`: latch step, set data register to `cmd_base_i`, remaining = `cmd_len_i`, clear `beats_sent_o`.
  - If `cmd_len_i`≠0, go to SEND.
  - If `cmd_len_i`=0, stay IDLE and pulse `done_o` the next cycle.
- SEND: `cmd_ready_o`=0, `valid_out_o`=1, `busy_o`=1. `last_out_o`=1 when remaining==1.
- Output handshake occurs when `valid_out_o` && `ready_out_i` at a rising edge. On each handshake:
  - `data_out_o` += step, modulo 2^WIDTH (wrap silently).
  - remaining -= 1; `beats_sent_o` += 1.
  - If this was the last beat, go to IDLE and pulse `done_o` the next cycle.
- Without a handshake, `valid_out_o`, `data_out_o` and `last_out_o` hold stable. Valid never drops before acceptance.
- Beat k (0-based) carries base + k·step, truncated to WIDTH.
- `cmd_len_i` = 2^CNT_W−1 is the maximum burst. The counter never wraps within a burst.
- `cmd_valid_i` while busy is ignored (not accepted). Command fields are sampled only at acceptance.
- Reset values: `cmd_ready_o`=1 (combinational from IDLE), `valid_out_o`=0, `data_out_o`=0, `last_out_o`=0, `busy_o`=0, `done_o`=0, `beats_sent_o`=0.
- Reset mid-burst: the burst aborts with no completion pulse. All outputs take reset values after the edge; the beat in flight is dropped.

## Timing
- All outputs are registered except `cmd_ready_o`, which decodes state only (no combinational input-to-output path).
- Command accepted at edge t: first beat valid in the cycle following t.
- Throughput is 1 beat/cycle with `ready_out_i` held high. N-beat burst: valid for exactly N cycles.
- Final handshake at edge t:
  - after t: IDLE, `done_o`=1 for one cycle, `cmd_ready_o`=1;
  - a new command may be accepted at edge t+1, so its first beat appears after t+1.
- Minimum gap between bursts is one idle cycle.
- `done_o` and `beats_sent_o` update at the same edge. `beats_sent_o` holds its final value until the next command is accepted.

## Test plan
- Reset, then base=0x10, step=4, len=4, ready=1: data 0x10, 0x14, 0x18, 0x1C on 4 consecutive cycles; last only on 0x1C; `done_o` one cycle later; `beats_sent_o`=4.
- Same command with `ready_out_i` toggling 1,0,0,1,0,1,1: valid stays high, data stable during stalls, sequence unchanged; completes after the 4th handshake.
- base=0xFFFFFFFE, step=1, len=3: data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- len=0: `cmd_ready_o` stays 1, no valid beat, `done_o` pulses the cycle after acceptance, `beats_sent_o`=0.
- Back-to-back: second command held on `cmd_valid_i` during burst 1 (len=2) is not accepted until the IDLE cycle. Its first beat appears two cycles after burst 1's last handshake; its fields are sampled only at acceptance.
- `rst_ni`=0 after 2 of 5 beats: next cycle `valid_out_o`=0, `busy_o`=0, `beats_sent_o`=0, no `done_o`; a new command after reset runs normally.
